regfile_sb: RTL and testbench

Parametrised, multi-read-port general-purpose register file with write-to-read bypass and a per-register busy scoreboard. It is the next-generation replacement for the datapath's 32×32 two-read/one-write register file. It sits in decode: combinational operand reads, write-back at the clock edge, and busy tracking so decode can detect RAW hazards against in-flight producers.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_rdport.sv | 41 ++++
 rtl/regfile_sb.sv | 102 ++++++++++
 tb/tb_regfile_sb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the decode-stage register file.
// No logic: constants and typedefs only.
// No flow control; consumers pick widths from here or override per instance.
package regfile_pkg;

  // Default geometry of the register file (32 x 32-bit).
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Architectural zero register index.
  localparam int ZERO_ADDR = 0;

  // Register contents are two's-complement signed at the default width.
  typedef logic signed [RF_DATA_W-1:0] rf_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One combinational operand read port: zero-reg, write bypass, then storage.
// Latency: 0 cycles, purely combinational from address and write-back inputs.
// No backpressure; ready reflects only the scoreboard and same-cycle bypass.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_store,
  input  logic              rd_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ready
);

  logic is_zero;
  logic byp_hit;

  assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_ADDR));
  assign byp_hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);

  // Operand select in priority order: hard-wired zero, forwarded write, stored value.
  always_comb begin
    rd_data  = rd_store;
    rd_ready = ~rd_busy;
    if (is_zero) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end else if (byp_hit) begin
      rd_data  = wr_data;
      rd_ready = 1'b1;
    end
  end

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass and per-register busy scoreboard.
// Latency: reads 0 cycles; writes and scoreboard updates visible after the clock edge.
// No backpressure: every write-back and issue is accepted in the cycle presented.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  output logic [NUM_RD-1:0]        ReadReady,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteReg,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic                     IssueValid,
  input  logic [ADDR_W-1:0]        IssueReg,
  output logic [(1<<ADDR_W)-1:0]   Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              iss_ok;

  // Writes and issues aimed at the hard-wired zero register are discarded.
  assign wr_ok  = RegWrite &&
                  !((ZERO_REG != 0) && (WriteReg == ADDR_W'(ZERO_ADDR)));
  assign iss_ok = IssueValid &&
                  !((ZERO_REG != 0) && (IssueReg == ADDR_W'(ZERO_ADDR)));

  // Register storage: cleared by reset, written at the edge on write-back.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Scoreboard next state: a new issue beats a same-cycle write-back to the same register.
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (iss_ok && (IssueReg == ADDR_W'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if (RegWrite && (WriteReg == ADDR_W'(r))) begin
        busy_nxt[r] = 1'b0;
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign Busy = busy_q;

  // One read-port mux per operand; storage lookup happens here, selection in the port.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;

    assign addr = ReadReg[i*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .rd_addr  (addr),
      .rd_store (regs[addr]),
      .rd_busy  (busy_q[addr]),
      .wr_en    (RegWrite),
      .wr_addr  (WriteReg),
      .wr_data  (WriteData),
      .rd_data  (data),
      .rd_ready (ready)
    );

    assign ReadData[i*DATA_W +: DATA_W] = data;
    assign ReadReady[i]                 = ready;
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  import regfile_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset_n;

  int checks = 0;
  int errors = 0;

  // Default instance: 32x32, two read ports, zero reg, bypass on.
  logic [9:0]  rr;
  logic [63:0] rd;
  logic [1:0]  rdy;
  logic        we;
  logic [4:0]  wr;
  rf_data_t    wd;
  logic        iv;
  logic [4:0]  ir;
  logic [31:0] busy;

  regfile_sb dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReadReg(rr), .ReadData(rd), .ReadReady(rdy),
    .RegWrite(we), .WriteReg(wr), .WriteData(wd), .IssueValid(iv), .IssueReg(ir),
    .Busy(busy)
  );

  // Bypass disabled instance.
  logic [9:0]  nb_rr;
  logic [63:0] nb_rd;
  logic [1:0]  nb_rdy;
  logic        nb_we;
  logic [4:0]  nb_wr;
  logic [31:0] nb_wd;
  logic        nb_iv;
  logic [4:0]  nb_ir;
  logic [31:0] nb_busy;

  regfile_sb #(.BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset_n(Reset_n), .ReadReg(nb_rr), .ReadData(nb_rd), .ReadReady(nb_rdy),
    .RegWrite(nb_we), .WriteReg(nb_wr), .WriteData(nb_wd), .IssueValid(nb_iv),
    .IssueReg(nb_ir), .Busy(nb_busy)
  );

  // Wide instance: 64 registers of 64 bits, four read ports.
  logic [23:0]  w_rr;
  logic [255:0] w_rd;
  logic [3:0]   w_rdy;
  logic         w_we;
  logic [5:0]   w_wr;
  logic [63:0]  w_wd;
  logic         w_iv;
  logic [5:0]   w_ir;
  logic [63:0]  w_busy;

  regfile_sb #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .ReadReg(w_rr), .ReadData(w_rd), .ReadReady(w_rdy),
    .RegWrite(w_we), .WriteReg(w_wr), .WriteData(w_wd), .IssueValid(w_iv),
    .IssueReg(w_ir), .Busy(w_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic        y0;
    logic [31:0] d1;
    logic        y1;
    logic [31:0] busy;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // we wr wd iv ir r0 r1 | d0 y0 d1 y1 busy
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd1,  32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    tbl[1]  = '{1'b1, 5'd7,  32'hFFFFFFFB, 1'b0, 5'd0, 5'd7,  5'd7,  32'hFFFFFFFB, 1'b1, 32'hFFFFFFFB, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  32'hFFFFFFFB, 1'b1, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b1, 5'd0, 5'd0,  5'd0,  32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd7,  32'h0,        1'b1, 32'hFFFFFFFB, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3,  5'd3,  32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd7,  32'h0,        1'b0, 32'hFFFFFFFB, 1'b1, 32'h8};
    tbl[7]  = '{1'b1, 5'd3,  32'd42,       1'b0, 5'd0, 5'd3,  5'd3,  32'd42,       1'b1, 32'd42,       1'b1, 32'h8};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd3,  32'd42,       1'b1, 32'd42,       1'b1, 32'h0};
    tbl[9]  = '{1'b1, 5'd9,  32'd11,       1'b1, 5'd9, 5'd9,  5'd7,  32'd11,       1'b1, 32'hFFFFFFFB, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'd11,       1'b0, 32'd11,       1'b0, 32'h200};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6, 5'd6,  5'd9,  32'h0,        1'b1, 32'd11,       1'b0, 32'h200};
    tbl[12] = '{1'b1, 5'd6,  32'd77,       1'b1, 5'd4, 5'd6,  5'd4,  32'd77,       1'b1, 32'h0,        1'b1, 32'h240};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd6,  5'd4,  32'd77,       1'b1, 32'h0,        1'b0, 32'h210};
    tbl[14] = '{1'b1, 5'd9,  32'd5,        1'b0, 5'd0, 5'd9,  5'd4,  32'd5,        1'b1, 32'h0,        1'b0, 32'h210};
    tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 5'd4,  5'd9,  32'h0,        1'b0, 32'd5,        1'b1, 32'h010};
    tbl[16] = '{1'b1, 5'd4,  32'hFFFFFFFF, 1'b0, 5'd0, 5'd4,  5'd4,  32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h010};
    tbl[17] = '{1'b1, 5'd12, 32'h55,       1'b0, 5'd0, 5'd12, 5'd4,  32'h55,       1'b1, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd12, 5'd31, 32'h55,       1'b1, 32'h0,        1'b1, 32'h0};

    Reset_n = 1'b0;
    rr = '0; we = 1'b0; wr = '0; wd = '0; iv = 1'b0; ir = '0;
    nb_rr = '0; nb_we = 1'b0; nb_wr = '0; nb_wd = '0; nb_iv = 1'b0; nb_ir = '0;
    w_rr = '0; w_we = 1'b0; w_wr = '0; w_wd = '0; w_iv = 1'b0; w_ir = '0;
    rr = {5'd1, 5'd2};
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_rd", rd, 64'h0);
    chk("reset_rdy", {62'h0, rdy}, 64'h3);
    chk("reset_busy", {32'h0, busy}, 64'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Table-driven main sequence on the default instance.
    for (int i = 0; i < 19; i++) begin
      @(negedge Clk);
      we = tbl[i].we; wr = tbl[i].wr; wd = tbl[i].wd;
      iv = tbl[i].iv; ir = tbl[i].ir;
      rr = {tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("v%0d_d0", i), {32'h0, rd[31:0]},  {32'h0, tbl[i].d0});
      chk($sformatf("v%0d_y0", i), {63'h0, rdy[0]},    {63'h0, tbl[i].y0});
      chk($sformatf("v%0d_d1", i), {32'h0, rd[63:32]}, {32'h0, tbl[i].d1});
      chk($sformatf("v%0d_y1", i), {63'h0, rdy[1]},    {63'h0, tbl[i].y1});
      chk($sformatf("v%0d_busy", i), {32'h0, busy},    {32'h0, tbl[i].busy});
    end

    // Asynchronous reset mid-cycle after writing r5 and issuing r8.
    @(negedge Clk);
    we = 1'b1; wr = 5'd5; wd = 32'h1234; iv = 1'b1; ir = 5'd8; rr = {5'd8, 5'd5};
    @(negedge Clk);
    we = 1'b0; iv = 1'b0;
    #1;
    chk("pre_rst_r5", {32'h0, rd[31:0]}, 64'h1234);
    chk("pre_rst_busy", {32'h0, busy}, 64'h100);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_rd", rd, 64'h0);
    chk("async_rst_rdy", {62'h0, rdy}, 64'h3);
    chk("async_rst_busy", {32'h0, busy}, 64'h0);
    // Write and issue coincident with a held reset are lost.
    we = 1'b1; wr = 5'd5; wd = 32'h99; iv = 1'b1; ir = 5'd8;
    @(posedge Clk);
    @(negedge Clk);
    we = 1'b0; iv = 1'b0;
    Reset_n = 1'b1;
    #1;
    chk("rst_lost_r5", {32'h0, rd[31:0]}, 64'h0);
    chk("rst_lost_busy", {32'h0, busy}, 64'h0);

    // Bypass disabled: old value in the write cycle, new value afterwards.
    @(negedge Clk);
    nb_we = 1'b1; nb_wr = 5'd7; nb_wd = 32'hFFFFFFFB; nb_rr = {5'd7, 5'd7};
    #1;
    chk("nb_same_cycle", {32'h0, nb_rd[31:0]}, 64'h0);
    @(negedge Clk);
    nb_we = 1'b0;
    #1;
    chk("nb_next_cycle", {32'h0, nb_rd[31:0]}, 64'hFFFFFFFB);
    @(negedge Clk);
    nb_iv = 1'b1; nb_ir = 5'd3; nb_rr = {5'd3, 5'd3};
    @(negedge Clk);
    nb_iv = 1'b0; nb_we = 1'b1; nb_wr = 5'd3; nb_wd = 32'd42;
    #1;
    chk("nb_wb_not_ready", {62'h0, nb_rdy}, 64'h0);
    chk("nb_wb_old_data", {32'h0, nb_rd[31:0]}, 64'h0);
    @(negedge Clk);
    nb_we = 1'b0;
    #1;
    chk("nb_after_wb_rdy", {62'h0, nb_rdy}, 64'h3);
    chk("nb_after_wb_data", {32'h0, nb_rd[63:32]}, 64'd42);

    // Wide instance: all four ports read r63 after a write, then scoreboard top bit.
    @(negedge Clk);
    w_we = 1'b1; w_wr = 6'd63; w_wd = 64'h8000_0000_0000_0001;
    w_iv = 1'b1; w_ir = 6'd63;
    @(negedge Clk);
    w_we = 1'b0; w_iv = 1'b0;
    w_rr = {6'd63, 6'd63, 6'd63, 6'd63};
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("wide_p%0d", p), w_rd[p*64 +: 64], 64'h8000_0000_0000_0001);
    end
    chk("wide_busy", w_busy, 64'h8000_0000_0000_0000);
    chk("wide_rdy", {60'h0, w_rdy}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_sb
